// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the fetch front end.
//   fetch_state_t   : fetch controller states
//   RESET_PC_DEFAULT: PC of the first fetch after reset
//   RMASK_WORD      : read mask for a full 32-bit instruction fetch
//   word_align()    : clears the two low address bits
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
    localparam logic [3:0]  RMASK_WORD       = 4'hf;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Front-end fetch stage. Owns the PC, drives the instruction-memory request
// port with a held request / single-cycle response handshake, and pushes
// {inst, pc} pairs into the instruction queue. A one-entry hold buffer
// absorbs a response that arrives while the queue is full. Flush redirects
// the PC; a response still in flight for the old path is drained and dropped.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   imem_addr     fetch address (word aligned), registered
//   imem_rmask    4'hf while a request is outstanding, registered
//   imem_rdata    returned instruction, valid with imem_resp
//   imem_resp     one-cycle response strobe
//   iq_full       instruction queue cannot accept a push
//   flush         redirect pulse, flush_pc is the target
//   fetch_valid   one-cycle push strobe, with fetch_inst / fetch_pc
//
// state   | meaning
// IDLE    | first cycle out of reset, nothing issued yet
// WAIT    | request at pc outstanding
// HOLD    | response parked in hold buffer, queue full, no request out
// DISCARD | request outstanding for a flushed path, result will be dropped
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        iq_full,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_d;
    logic [3:0]   rmask_d;
    logic         valid_d;
    logic [31:0]  inst_d, fpc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic         hold_valid_q, hold_valid_d;
    logic [31:0]  flush_target;

    assign flush_target = word_align(flush_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            imem_addr    <= '0;
            imem_rmask   <= '0;
            fetch_valid  <= 1'b0;
            fetch_inst   <= '0;
            fetch_pc     <= '0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            imem_addr    <= addr_d;
            imem_rmask   <= rmask_d;
            fetch_valid  <= valid_d;
            fetch_inst   <= inst_d;
            fetch_pc     <= fpc_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = imem_addr;
        rmask_d      = imem_rmask;
        valid_d      = 1'b0;
        inst_d       = fetch_inst;
        fpc_d        = fetch_pc;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;

        if (flush) begin
            pc_d         = flush_target;
            hold_valid_d = 1'b0;
            case (state_q)
                WAIT: begin
                    if (imem_resp) begin
                        addr_d  = flush_target;
                        rmask_d = RMASK_WORD;
                    end else begin
                        // Request must stay on the bus until its response.
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    // Old request completing now frees the port for the target.
                    if (imem_resp) begin
                        addr_d  = flush_target;
                        rmask_d = RMASK_WORD;
                        state_d = WAIT;
                    end
                end
                default: begin
                    addr_d  = flush_target;
                    rmask_d = RMASK_WORD;
                    state_d = WAIT;
                end
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    addr_d  = pc_q;
                    rmask_d = RMASK_WORD;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (imem_resp) begin
                        if (!iq_full) begin
                            valid_d = 1'b1;
                            inst_d  = imem_rdata;
                            fpc_d   = pc_q;
                            pc_d    = pc_q + 32'd4;
                            addr_d  = pc_q + 32'd4;
                        end else begin
                            hold_inst_d  = imem_rdata;
                            hold_pc_d    = pc_q;
                            hold_valid_d = 1'b1;
                            rmask_d      = '0;
                            state_d      = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!iq_full && hold_valid_q) begin
                        valid_d      = 1'b1;
                        inst_d       = hold_inst_q;
                        fpc_d        = hold_pc_q;
                        hold_valid_d = 1'b0;
                        pc_d         = pc_q + 32'd4;
                        addr_d       = pc_q + 32'd4;
                        rmask_d      = RMASK_WORD;
                        state_d      = WAIT;
                    end
                end
                DISCARD: begin
                    // pc already holds the redirect target.
                    if (imem_resp) begin
                        addr_d  = pc_q;
                        rmask_d = RMASK_WORD;
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 1'b0;
    logic        iq_full = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .iq_full(iq_full), .flush(flush), .flush_pc(flush_pc),
        .fetch_valid(fetch_valid), .fetch_inst(fetch_inst), .fetch_pc(fetch_pc)
    );

    int     n_total = 0;
    int     n_pass  = 0;
    longint cyc     = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- memory responder ----------------
    int          lat = 1;
    int          rcnt = 0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] resp_addr = '0;

    always @(negedge clk) begin
        if (!rst_n || imem_rmask != 4'hf) begin
            imem_resp = 1'b0;
            rcnt = 0;
        end else if (imem_resp) begin
            imem_resp = 1'b0;
            rcnt = 1;
        end else begin
            if (rcnt >= lat) begin
                imem_resp = 1'b1;
                resp_addr = imem_addr;
                if (force_en) begin
                    imem_rdata = force_val;
                    force_en = 1'b0;
                end else begin
                    imem_rdata = mem_word(imem_addr);
                end
            end
            rcnt++;
        end
    end

    // ---------------- transaction model + per-cycle compare ----------------
    logic [31:0] m_pc = RPC, m_req_addr = '0, m_pend_inst = '0, m_pend_pc = '0;
    bit          m_started = 0, m_req_out = 0, m_stale = 0, m_pend = 0;
    bit          e_valid;
    logic [31:0] e_inst, e_pc;
    logic [31:0] p_addr = '0;
    logic [3:0]  p_rmask = '0;
    bit          p_ok = 0;
    logic        s_resp, s_full, s_flush;
    logic [31:0] s_rdata, s_fpc;

    always begin
        @(posedge clk);
        cyc++;
        s_resp = imem_resp; s_full = iq_full; s_flush = flush;
        s_rdata = imem_rdata; s_fpc = flush_pc;
        if (!rst_n) begin
            m_pc = RPC; m_started = 0; m_req_out = 0; m_stale = 0; m_pend = 0;
            p_ok = 0;
            #1;
            chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
            chk("rst_rmask", {28'b0, imem_rmask}, 32'd0);
        end else begin
            e_valid = 0; e_inst = '0; e_pc = '0;
            if (s_flush) begin
                m_pc = s_fpc & ~32'h3;
                m_pend = 0;
                if (m_started && m_req_out && !s_resp) m_stale = 1;
                else begin m_req_out = 1; m_req_addr = m_pc; m_stale = 0; end
                m_started = 1;
            end else if (!m_started) begin
                m_started = 1; m_req_out = 1; m_req_addr = m_pc;
            end else if (m_req_out && s_resp) begin
                if (m_stale) begin
                    m_stale = 0; m_req_addr = m_pc;
                end else if (!s_full) begin
                    e_valid = 1; e_inst = s_rdata; e_pc = m_req_addr;
                    m_pc = m_pc + 32'd4; m_req_addr = m_pc;
                end else begin
                    m_pend = 1; m_pend_inst = s_rdata; m_pend_pc = m_req_addr;
                    m_req_out = 0;
                end
            end else if (m_pend && !s_full) begin
                e_valid = 1; e_inst = m_pend_inst; e_pc = m_pend_pc; m_pend = 0;
                m_pc = m_pc + 32'd4; m_req_out = 1; m_req_addr = m_pc;
            end
            #1;
            chk("model_valid", {31'b0, fetch_valid}, {31'b0, e_valid});
            if (e_valid) begin
                chk("model_inst", fetch_inst, e_inst);
                chk("model_pc", fetch_pc, e_pc);
            end
            chk("model_rmask", {28'b0, imem_rmask}, m_req_out ? 32'hf : 32'h0);
            if (m_req_out) chk("model_addr", imem_addr, m_req_addr);
            if (p_ok && p_rmask == 4'hf && !s_resp) begin
                chk("held_addr", imem_addr, p_addr);
                chk("held_rmask", {28'b0, imem_rmask}, {28'b0, p_rmask});
            end
            p_ok = 1; p_addr = imem_addr; p_rmask = imem_rmask;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_push(input string name, input logic [31:0] epc,
                             input logic [31:0] einst, output longint at);
        bit got = 0;
        at = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #2;
            if (fetch_valid) begin
                chk({name, "_pc"}, fetch_pc, epc);
                chk({name, "_inst"}, fetch_inst, einst);
                at = cyc;
                got = 1;
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_no_resp();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (!imem_resp) return;
        end
        chk("no_resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_hold(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (imem_rmask == 4'h0) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_resp(input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (imem_resp) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'd0);
        chk({tag, "_rmask"}, {28'b0, imem_rmask}, 32'd0);
        chk({tag, "_valid"}, {31'b0, fetch_valid}, 32'd0);
        chk({tag, "_inst"},  fetch_inst, 32'd0);
        chk({tag, "_pc"},    fetch_pc, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint t0, t1, t2;
        bit     found;

        // reset
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // straight-line fetch, latency 1
        wait_push("seq0", 32'h1eceb000, 32'h4494b000, t0);
        wait_push("seq1", 32'h1eceb004, 32'h4494b004, t1);
        wait_push("seq2", 32'h1eceb008, 32'h4494b008, t2);
        chk("seq_gap01", 32'(t1 - t0), 32'd2);
        chk("seq_gap12", 32'(t2 - t1), 32'd2);

        // queue full over a response: park, then one push of the held word
        wait_no_resp();
        iq_full = 1'b1; force_val = 32'h00500093; force_en = 1'b1;
        wait_hold("hold_enter");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("hold_no_push", {31'b0, fetch_valid}, 32'd0);
            chk("hold_no_req", {28'b0, imem_rmask}, 32'd0);
        end
        @(negedge clk); #1 iq_full = 1'b0;
        wait_push("hold_push", resp_addr, 32'h00500093, t0);

        // flush while waiting, latency 4: stale word dropped
        lat = 4;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_rmask == 4'hf && rcnt == 1 && !imem_resp) found = 1;
        end
        if (!found) chk("discard_setup_timeout", 32'd0, 32'd1);
        flush = 1'b1; flush_pc = 32'h1eceb100;
        @(negedge clk); #1 flush = 1'b0;
        wait_resp("stale_resp");
        @(posedge clk); #2;
        chk("discard_next_addr", imem_addr, 32'h1eceb100);
        chk("discard_no_push", {31'b0, fetch_valid}, 32'd0);
        wait_push("discard_push", 32'h1eceb100, 32'h4494b100, t0);

        // flush coincident with a response
        lat = 2;
        wait_resp("coinc_resp");
        flush = 1'b1; flush_pc = 32'h1eceb200;
        @(posedge clk); #2;
        chk("coinc_addr", imem_addr, 32'h1eceb200);
        chk("coinc_valid", {31'b0, fetch_valid}, 32'd0);
        chk("coinc_rmask", {28'b0, imem_rmask}, 32'hf);
        @(negedge clk); #1 flush = 1'b0;
        wait_push("coinc_push", 32'h1eceb200, 32'h4494b200, t0);

        // flush with misaligned target while parked in the hold buffer
        lat = 1;
        wait_no_resp();
        iq_full = 1'b1;
        wait_hold("hflush_enter");
        flush = 1'b1; flush_pc = 32'h1eceb102;
        @(posedge clk); #2;
        chk("hflush_addr", imem_addr, 32'h1eceb100);
        chk("hflush_rmask", {28'b0, imem_rmask}, 32'hf);
        chk("hflush_valid", {31'b0, fetch_valid}, 32'd0);
        @(negedge clk); #1 flush = 1'b0; iq_full = 1'b0;
        wait_push("hflush_push", 32'h1eceb100, 32'h4494b100, t0);

        // PC wrap at the top of the address space
        @(negedge clk); #1 flush = 1'b1; flush_pc = 32'hfffffff8;
        @(negedge clk); #1 flush = 1'b0;
        wait_push("wrap0", 32'hfffffff8, 32'ha5a5fff8, t0);
        wait_push("wrap1", 32'hfffffffc, 32'ha5a5fffc, t0);
        wait_push("wrap2", 32'h00000000, 32'h5a5a0000, t0);

        // asynchronous reset in the middle of a request
        lat = 3;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_rmask == 4'hf && !imem_resp) found = 1;
        end
        if (!found) chk("midrst_setup_timeout", 32'd0, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        wait_push("refetch", RPC, 32'h4494b000, t0);

        repeat (4) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
